conv_layer_1d: RTL

CONV_LAYER_1D -- requirements
Module: conv_layer_1d

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/conv_mac.sv | 31 +++
 rtl/conv_layer_1d.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the 1-D convolution layer.
// Holds the layer FSM state type and the output saturate/ReLU stage.
package cnn_pkg;

   typedef enum logic [1:0] {
      LOAD_W,
      LOAD_X,
      COMPUTE
   } conv_state_t;

   localparam int SAT_W = 64;

   // Clamp a sign-extended accumulator into a signed 'width'-bit range, then optionally drop negatives.
   function automatic logic signed [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] value,
                                                        input int width,
                                                        input logic relu);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] res;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)
         res = hi;
      else if (value < lo)
         res = lo;
      else
         res = value;
      if (relu && (res < 0))
         res = '0;
      return res;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulate lane for the convolution layer.
// Clear has priority over enable so an output load and accumulator restart share one cycle.
module conv_mac
   import cnn_pkg::*;
#(
   parameter int T     = 16,
   parameter int ACC_W = 36
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    enable,
   input  logic signed [T-1:0]     a,
   input  logic signed [T-1:0]     b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*T-1:0] product;

   assign product = a * b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (clear)
         acc <= '0;
      else if (enable)
         acc <= acc + ACC_W'(product);
   end

endmodule

// File: rtl/conv_layer_1d.sv
// Streaming 1-D valid convolution: load M weights, load N samples, emit N-M+1 outputs.
// One MAC per cycle plus one output-register load per result.
module conv_layer_1d
   import cnn_pkg::*;
#(
   parameter int T    = 16,
   parameter int N    = 64,
   parameter int M    = 9,
   parameter int FRAC = 0,
   parameter int RELU = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [T-1:0] x_data,
   input  logic                x_valid,
   output logic                x_ready,
   input  logic signed [T-1:0] w_data,
   input  logic                w_valid,
   output logic                w_ready,
   output logic signed [T-1:0] y_data,
   output logic                y_valid,
   input  logic                y_ready
);

   localparam int ACC_W = 2 * T + $clog2(M);
   localparam int XW    = (N > 1) ? $clog2(N) : 1;
   localparam int FW    = (M > 1) ? $clog2(M) : 1;
   localparam int TW    = $clog2(M + 1);

   localparam logic [XW-1:0] X_LAST   = XW'(N - 1);
   localparam logic [XW-1:0] W_LAST   = XW'(M - 1);
   localparam logic [XW-1:0] K_LAST   = XW'(N - M);
   localparam logic [TW-1:0] TAP_LOAD = TW'(M);

   conv_state_t state;

   logic signed [T-1:0] x_buf [N];
   logic signed [T-1:0] f_buf [M];

   logic [XW-1:0] ld_cnt;
   logic [XW-1:0] k_idx;
   logic [TW-1:0] tap;
   logic          last_out;

   logic                    advance;
   logic                    mac_en;
   logic                    mac_clr;
   logic [XW-1:0]           x_idx;
   logic [FW-1:0]           f_idx;
   logic signed [T-1:0]     x_op;
   logic signed [T-1:0]     f_op;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sh;
   logic signed [T-1:0]     y_next;

   // The whole compute pipeline freezes while a finished result sits unread in the output register.
   always_comb begin
      advance = !y_valid || y_ready;
      mac_en  = (state == COMPUTE) && !last_out && advance && (tap != TAP_LOAD);
      mac_clr = (state == COMPUTE) && !last_out && advance && (tap == TAP_LOAD);
      x_idx   = XW'(32'(k_idx) + 32'(tap));
      f_idx   = tap[FW-1:0];
      x_op    = x_buf[x_idx];
      f_op    = f_buf[f_idx];
      acc_sh  = acc >>> FRAC;
      y_next  = T'(sat_relu(SAT_W'(acc_sh), T, RELU != 0));
   end

   conv_mac #(
      .T     (T),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clear  (mac_clr),
      .enable (mac_en),
      .a      (x_op),
      .b      (f_op),
      .acc    (acc)
   );

   // Sample and weight storage is never reset; it is always rewritten before use.
   always_ff @(posedge clk) begin
      if ((state == LOAD_W) && w_valid && w_ready)
         f_buf[ld_cnt[FW-1:0]] <= w_data;
      if ((state == LOAD_X) && x_valid && x_ready)
         x_buf[ld_cnt] <= x_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= LOAD_W;
         x_ready  <= 1'b0;
         w_ready  <= 1'b0;
         y_valid  <= 1'b0;
         y_data   <= '0;
         ld_cnt   <= '0;
         k_idx    <= '0;
         tap      <= '0;
         last_out <= 1'b0;
      end else begin
         case (state)
            LOAD_W: begin
               w_ready <= 1'b1;
               if (w_valid && w_ready) begin
                  if (ld_cnt == W_LAST) begin
                     ld_cnt  <= '0;
                     w_ready <= 1'b0;
                     x_ready <= 1'b1;
                     state   <= LOAD_X;
                  end else begin
                     ld_cnt <= ld_cnt + 1'b1;
                  end
               end
            end
            LOAD_X: begin
               x_ready <= 1'b1;
               if (x_valid && x_ready) begin
                  if (ld_cnt == X_LAST) begin
                     ld_cnt  <= '0;
                     x_ready <= 1'b0;
                     state   <= COMPUTE;
                  end else begin
                     ld_cnt <= ld_cnt + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               // Last result is loaded; leave only once it has been taken downstream.
               if (last_out) begin
                  if (y_valid && y_ready) begin
                     y_valid  <= 1'b0;
                     last_out <= 1'b0;
                     k_idx    <= '0;
                     tap      <= '0;
                     if (w_valid) begin
                        state   <= LOAD_W;
                        w_ready <= 1'b1;
                     end else begin
                        state   <= LOAD_X;
                        x_ready <= 1'b1;
                     end
                  end
               end else if (advance) begin
                  if (tap != TAP_LOAD) begin
                     tap <= tap + 1'b1;
                     if (y_ready)
                        y_valid <= 1'b0;
                  end else begin
                     y_data  <= y_next;
                     y_valid <= 1'b1;
                     tap     <= '0;
                     if (k_idx == K_LAST)
                        last_out <= 1'b1;
                     else
                        k_idx <= k_idx + 1'b1;
                  end
               end
            end
            default: state <= LOAD_W;
         endcase
      end
   end

endmodule
